// File: rtl/anc_pkg.sv
// Shared types and constants for the ANC sample-rate controller and its FIR datapath.
package anc_pkg;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StMul  = 3'd1,
        StGo   = 3'd2,
        StWait = 3'd3,
        StOut  = 3'd4
    } anc_state_e;

    localparam logic signed [15:0] Q15Max = 16'sh7fff;
    localparam logic signed [15:0] Q15Min = 16'sh8000;

    localparam int unsigned TapsDefault = 128;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] e;
        logic [15:0] a;
    } anc_frame_t;

endpackage

// File: rtl/bw_mult.sv
// Signed two's-complement multiplier producing a full-width product.
module bw_mult #(
    parameter int unsigned Width = 16
) (
    input  logic signed [Width-1:0]   a_i,
    input  logic signed [Width-1:0]   b_i,
    output logic signed [2*Width-1:0] p_o
);

    assign p_o = a_i * b_i;

endmodule

// File: rtl/saturate.sv
// Clamps a signed value to a narrower signed range.
module saturate #(
    parameter int unsigned InW  = 17,
    parameter int unsigned OutW = 16
) (
    input  logic signed [InW-1:0]  din_i,
    output logic signed [OutW-1:0] dout_o
);

    logic ovf;

    always_comb begin
        // Fits only if every bit above the output sign bit matches the input sign.
        ovf = (din_i[InW-1:OutW-1] != {(InW-OutW+1){din_i[InW-1]}});
        if (!ovf) begin
            dout_o = din_i[OutW-1:0];
        end else if (din_i[InW-1]) begin
            dout_o = {1'b1, {(OutW-1){1'b0}}};
        end else begin
            dout_o = {1'b0, {(OutW-1){1'b1}}};
        end
    end

endmodule

// File: rtl/anc_fir_ctrl.sv
// Sample-rate controller: latches ADC frames, launches one FIR run per frame and hands the
// result to the DAC with a valid/ready hold, buffering one frame while busy.
module anc_fir_ctrl
    import anc_pkg::*;
#(
    parameter int unsigned TAPS    = TapsDefault,
    parameter int unsigned TIMEOUT = 512,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adc_valid,
    input  logic [15:0]      adc_x,
    input  logic [15:0]      adc_e,
    input  logic [15:0]      adc_a,
    input  logic [15:0]      mu,
    input  logic             adapt_en,
    output logic [15:0]      fir_x_in,
    output logic [15:0]      fir_a_in,
    output logic [15:0]      fir_wadj,
    output logic             fir_go,
    input  logic [15:0]      fir_out,
    input  logic             fir_done,
    output logic [15:0]      dac_sample,
    output logic             dac_valid,
    input  logic             dac_ready,
    output logic             busy,
    output logic [CNT_W-1:0] overrun_cnt,
    output logic             timeout_err
);

    localparam int unsigned TmrW = $clog2(TIMEOUT + 1);

    if (TIMEOUT <= TAPS + 7) begin : g_bad_timeout
        $error("TIMEOUT must exceed the FIR run time TAPS+7");
    end

    anc_state_e        state_q, state_d;
    anc_frame_t        frame_q, frame_d;
    anc_frame_t        pend_q, pend_d;
    logic              pend_full_q, pend_full_d;
    logic [15:0]       mu_q, mu_d;
    logic [15:0]       wadj_q, wadj_d;
    logic [15:0]       fir_x_q, fir_x_d;
    logic [15:0]       fir_a_q, fir_a_d;
    logic              fir_go_q, fir_go_d;
    logic [TmrW-1:0]   timer_q, timer_d;
    logic [15:0]       dac_sample_q, dac_sample_d;
    logic              dac_valid_q, dac_valid_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  ovr_q, ovr_d;

    logic              idle;
    logic              consume;
    logic              capture;
    logic signed [31:0] prod;
    logic signed [15:0] wadj_sat;
    logic              unused_prod_lsbs;

    bw_mult #(
        .Width (16)
    ) u_mult (
        .a_i (mu_q),
        .b_i (frame_q.e),
        .p_o (prod)
    );

    // Q1.15 * Q1.15 -> Q2.30; bits [31:15] are the Q1.15 result with one guard bit.
    saturate #(
        .InW  (17),
        .OutW (16)
    ) u_sat (
        .din_i  (prod[31:15]),
        .dout_o (wadj_sat)
    );

    assign unused_prod_lsbs = ^prod[14:0];

    assign idle    = (state_q == StIdle);
    assign consume = idle && pend_full_q;
    assign capture = adc_valid && (!idle || consume);

    always_comb begin
        state_d      = state_q;
        frame_d      = frame_q;
        mu_d         = mu_q;
        wadj_d       = wadj_q;
        fir_x_d      = fir_x_q;
        fir_a_d      = fir_a_q;
        fir_go_d     = 1'b0;
        timer_d      = timer_q;
        dac_sample_d = dac_sample_q;
        dac_valid_d  = dac_valid_q;
        timeout_d    = timeout_q;
        unique case (state_q)
            StIdle: begin
                if (pend_full_q) begin
                    frame_d = pend_q;
                    mu_d    = mu;
                    state_d = StMul;
                end else if (adc_valid) begin
                    frame_d = '{x: adc_x, e: adc_e, a: adc_a};
                    mu_d    = mu;
                    state_d = StMul;
                end
            end
            StMul: begin
                wadj_d   = adapt_en ? wadj_sat : 16'h0000;
                fir_x_d  = frame_q.x;
                fir_a_d  = frame_q.a;
                fir_go_d = 1'b1;
                state_d  = StGo;
            end
            StGo: begin
                timer_d = '0;
                state_d = StWait;
            end
            StWait: begin
                if (fir_done) begin
                    dac_sample_d = fir_out;
                    dac_valid_d  = 1'b1;
                    state_d      = StOut;
                end else if (timer_q == TmrW'(TIMEOUT - 1)) begin
                    // Abort: re-present the previous sample so the DAC stream keeps its rate.
                    timeout_d   = 1'b1;
                    dac_valid_d = 1'b1;
                    state_d     = StOut;
                end else begin
                    timer_d = timer_q + TmrW'(1);
                end
            end
            StOut: begin
                if (dac_ready) begin
                    dac_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        ovr_d       = ovr_q;
        if (capture) begin
            // A slot being consumed this cycle is free for the incoming frame.
            if (!pend_full_q || consume) begin
                pend_d      = '{x: adc_x, e: adc_e, a: adc_a};
                pend_full_d = 1'b1;
            end else if (ovr_q != {CNT_W{1'b1}}) begin
                ovr_d = ovr_q + CNT_W'(1);
            end
        end else if (consume) begin
            pend_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            frame_q      <= '0;
            pend_q       <= '0;
            pend_full_q  <= 1'b0;
            mu_q         <= '0;
            wadj_q       <= '0;
            fir_x_q      <= '0;
            fir_a_q      <= '0;
            fir_go_q     <= 1'b0;
            timer_q      <= '0;
            dac_sample_q <= '0;
            dac_valid_q  <= 1'b0;
            timeout_q    <= 1'b0;
            ovr_q        <= '0;
        end else begin
            state_q      <= state_d;
            frame_q      <= frame_d;
            pend_q       <= pend_d;
            pend_full_q  <= pend_full_d;
            mu_q         <= mu_d;
            wadj_q       <= wadj_d;
            fir_x_q      <= fir_x_d;
            fir_a_q      <= fir_a_d;
            fir_go_q     <= fir_go_d;
            timer_q      <= timer_d;
            dac_sample_q <= dac_sample_d;
            dac_valid_q  <= dac_valid_d;
            timeout_q    <= timeout_d;
            ovr_q        <= ovr_d;
        end
    end

    assign fir_x_in    = fir_x_q;
    assign fir_a_in    = fir_a_q;
    assign fir_wadj    = wadj_q;
    assign fir_go      = fir_go_q;
    assign dac_sample  = dac_sample_q;
    assign dac_valid   = dac_valid_q;
    assign busy        = !idle;
    assign overrun_cnt = ovr_q;
    assign timeout_err = timeout_q;

endmodule
